// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt, addressed as three word registers (CTRL, PRESET, COUNT).
module timer_dev #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              irq_flag;

  logic       en;
  logic [1:0] mode;
  logic       im;

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];
  assign im   = ctrl[3];

  // irq depends only on registers, so addr activity cannot glitch it
  assign irq = irq_flag & im;

  always_comb begin
    rd = '0;
    unique case (addr)
      ADDR_CTRL:   rd = DATA_W'(ctrl);
      ADDR_PRESET: rd = DATA_W'(preset);
      ADDR_COUNT:  rd = DATA_W'(count);
      default:     rd = '0;
    endcase
  end

  // Counter FSM; CPU writes are applied last so they win over FSM updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode == MODE_RELOAD) begin
            irq_flag <= 1'b0;
            state    <= ST_LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (we && (addr == ADDR_CTRL)) begin
        ctrl     <= wd[CTRL_W-1:0];
        irq_flag <= 1'b0;
      end
      if (we && (addr == ADDR_PRESET)) begin
        preset   <= wd[CNT_W-1:0];
        irq_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected rd/irq values,
// a monitor compares them against the DUT on the falling clock edge.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  timer_dev #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  a;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one expectation consumed per falling edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (rd !== e.rd || irq !== e.irq) begin
        n_fail++;
        $display("FAIL %s: addr=%0d got rd=%h irq=%b, expected rd=%h irq=%b",
                 e.name, e.a, rd, irq, e.rd, e.irq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk(input string n, input logic [1:0] a,
                     input logic [31:0] r, input logic i);
    exp_t e;
    e.name = n;
    e.a    = a;
    e.rd   = r;
    e.irq  = i;
    addr   = a;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] c;
    logic        ei;
    int          p;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = '0;
    #12 rst_n = 1'b1;

    // Reset values
    for (int a = 0; a < 4; a++) chk("reset_rd", 2'(a), 32'h0, 1'b0);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    chk("os_t0", 2'd2, 32'd0, 1'b0);
    tick(); chk("os_load", 2'd2, 32'd0, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      tick(); chk("os_cnt", 2'd2, 32'(7 - k), 1'b0);
    end
    tick(); chk("os_irq", 2'd2, 32'd0, 1'b1);
    tick(); chk("os_en_clr", 2'd0, 32'h8, 1'b1);
    tick(); chk("os_irq_hold", 2'd0, 32'h8, 1'b1);
    wr(2'd0, 32'h8);
    chk("os_irq_clr", 2'd0, 32'h8, 1'b0);

    // One-shot with IM=0: irq never rises
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    chk("im0_t0", 2'd0, 32'h1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick(); chk("im0_run", 2'd0, (k <= 8) ? 32'h1 : 32'h0, 1'b0);
    end
    wr(2'd0, 32'h8);
    chk("im0_clr", 2'd0, 32'h8, 1'b0);

    // Auto-reload, PRESET=2: period 5
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    chk("ar_t0", 2'd2, 32'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      if (k == 1) begin
        c = 32'd0; ei = 1'b0;
      end else begin
        p  = (k - 2) % 5;
        c  = (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
        ei = (p == 3);
      end
      tick(); chk("ar_run", 2'd2, c, ei);
    end
    tick(); chk("ar_ctrl", 2'd0, 32'hB, 1'b0);

    // PRESET change during CNT takes effect only after the next LOAD
    wr(2'd1, 32'd7);
    chk("ar_pre_wr", 2'd2, 32'd0, 1'b0);
    tick(); chk("ar_irq_old", 2'd2, 32'd0, 1'b1);
    tick(); chk("ar_reload", 2'd1, 32'd7, 1'b0);
    tick(); chk("ar_new_load", 2'd2, 32'd7, 1'b0);
    for (int k = 23; k <= 29; k++) begin
      tick(); chk("ar_new_cnt", 2'd2, 32'(29 - k), 1'b0);
    end
    tick(); chk("ar_irq_new", 2'd2, 32'd0, 1'b1);
    tick(); chk("ar_irq_pulse", 2'd2, 32'd0, 1'b0);
    tick(); chk("ar_load2", 2'd2, 32'd7, 1'b0);
    for (int k = 33; k <= 36; k++) begin
      tick(); chk("ar_cnt2", 2'd2, 32'(39 - k), 1'b0);
    end

    // Disable mid-count: COUNT freezes, FSM idles
    wr(2'd0, 32'h0);
    chk("frz_edge", 2'd2, 32'd2, 1'b0);
    tick(); chk("frz_hold", 2'd2, 32'd2, 1'b0);
    tick(); chk("frz_ctrl", 2'd0, 32'h0, 1'b0);
    wr(2'd2, 32'h1234);
    chk("count_ro", 2'd2, 32'd2, 1'b0);
    wr(2'd3, 32'hFFFF_FFFF);
    chk("rsvd_rd", 2'd3, 32'h0, 1'b0);

    // PRESET=0: irq three edges after enable
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    chk("p0_t0", 2'd2, 32'd2, 1'b0);
    tick(); chk("p0_load", 2'd2, 32'd2, 1'b0);
    tick(); chk("p0_cnt", 2'd2, 32'd0, 1'b0);
    tick(); chk("p0_irq", 2'd2, 32'd0, 1'b1);

    // CTRL write on the INT edge: CPU value wins, flag cleared, FSM to IDLE
    wr(2'd0, 32'h9);
    chk("int_wr_ctrl", 2'd0, 32'h9, 1'b0);
    tick(); chk("int_wr_load", 2'd2, 32'd0, 1'b0);
    tick(); chk("int_wr_cnt", 2'd2, 32'd0, 1'b0);
    tick(); chk("int_wr_irq", 2'd2, 32'd0, 1'b1);
    tick(); chk("int_wr_done", 2'd0, 32'h8, 1'b1);

    // Async reset drops irq with no clock edge
    tick();
    rst_n = 1'b0;
    chk("rst_irq_async", 2'd0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Async reset mid-count
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    chk("mid_cnt", 2'd2, 32'd99, 1'b0);
    tick();
    rst_n = 1'b0;
    chk("rst_mid_count", 2'd2, 32'h0, 1'b0);
    chk("rst_mid_preset", 2'd1, 32'h0, 1'b0);
    rst_n = 1'b1;
    chk("rst_mid_ctrl", 2'd0, 32'h0, 1'b0);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
